// File: rtl/idma_desc64_desc_fetch_if.sv
// Descriptor fetch bus bundle.
// Groups the four handshakes of the descriptor fetcher:
//   desc_addr_* : descriptor addresses from the register frontend
//   rd_req_*    : read request to memory (address, beats-1)
//   rd_rsp_*    : read response beats from memory
//   desc_*      : assembled descriptor to the backend
// plus the fetch_err_o pulse and busy_o status.
// slave  = fetcher side, master = environment side.
interface idma_desc64_desc_fetch_if;
  logic [63:0] desc_addr_i;
  logic        desc_addr_valid_i;
  logic        desc_addr_ready_o;

  logic [63:0] rd_req_addr_o;
  logic [7:0]  rd_req_len_o;
  logic        rd_req_valid_o;
  logic        rd_req_ready_i;

  logic [63:0] rd_rsp_data_i;
  logic        rd_rsp_last_i;
  logic        rd_rsp_err_i;
  logic        rd_rsp_valid_i;
  logic        rd_rsp_ready_o;

  logic [31:0] desc_flags_o;
  logic [31:0] desc_length_o;
  logic [63:0] desc_next_o;
  logic [63:0] desc_src_o;
  logic [63:0] desc_dst_o;
  logic [63:0] desc_addr_o;
  logic        desc_valid_o;
  logic        desc_ready_i;

  logic        fetch_err_o;
  logic        busy_o;

  modport slave (
    input  desc_addr_i, desc_addr_valid_i,
    output desc_addr_ready_o,
    output rd_req_addr_o, rd_req_len_o, rd_req_valid_o,
    input  rd_req_ready_i,
    input  rd_rsp_data_i, rd_rsp_last_i, rd_rsp_err_i, rd_rsp_valid_i,
    output rd_rsp_ready_o,
    output desc_flags_o, desc_length_o, desc_next_o, desc_src_o, desc_dst_o,
    output desc_addr_o, desc_valid_o,
    input  desc_ready_i,
    output fetch_err_o, busy_o
  );

  modport master (
    output desc_addr_i, desc_addr_valid_i,
    input  desc_addr_ready_o,
    input  rd_req_addr_o, rd_req_len_o, rd_req_valid_o,
    output rd_req_ready_i,
    output rd_rsp_data_i, rd_rsp_last_i, rd_rsp_err_i, rd_rsp_valid_i,
    input  rd_rsp_ready_o,
    input  desc_flags_o, desc_length_o, desc_next_o, desc_src_o, desc_dst_o,
    input  desc_addr_o, desc_valid_o,
    output desc_ready_i,
    input  fetch_err_o, busy_o
  );
endinterface

// File: rtl/idma_desc64_desc_fetch.sv
// 64-bit iDMA descriptor fetcher.
// Queues descriptor addresses in a small FIFO, fetches each 32-byte
// descriptor as a 4-beat read (len = 3), and presents the assembled
// descriptor (flags, length, next, src, dst, fetch address).
// Misaligned addresses, response errors and malformed bursts are
// dropped with a one-cycle fetch_err_o pulse.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : idma_desc64_desc_fetch_if.slave (all handshakes, error, busy)
// Build option:
//   IDMA_DESC64_FETCH_OUT_BUF_EN : adds an output register so the next
//   fetch can proceed while the backend back-pressures the descriptor.
module idma_desc64_desc_fetch #(
  parameter  int unsigned AddrFifoDepth  = 2,
  localparam int unsigned MaxOutstanding = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  idma_desc64_desc_fetch_if.slave        bus
);
  localparam int unsigned PtrW = (AddrFifoDepth > 1) ? $clog2(AddrFifoDepth) : 1;
  localparam int unsigned CntW = $clog2(AddrFifoDepth + 1);

  typedef struct packed {
    logic [31:0] flags;
    logic [31:0] length;
    logic [63:0] next;
    logic [63:0] src;
    logic [63:0] dst;
    logic [63:0] addr;
  } desc_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_OUT} state_e;

  state_e          state;
  logic [63:0]     fifo_q [AddrFifoDepth];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [CntW-1:0] fifo_cnt, fifo_cnt_nxt;
  logic            addr_rdy_q;
  logic            push, pop;
  logic [63:0]     head;

  desc_t           asm_q, asm_nxt;
  logic [1:0]      beat_q;
  logic            err_q, beat_err;
  logic            req_vld_q, rsp_rdy_q, err_pulse_q;
  logic            rsp_hs;

`ifdef IDMA_DESC64_FETCH_OUT_BUF_EN
  desc_t           out_q;
  logic            out_vld_q;
  logic            out_free;
  assign out_free = ~out_vld_q | bus.desc_ready_i;
`else
  logic            desc_vld_q;
`endif

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(AddrFifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // address FIFO; ready is registered from the next occupancy so it is
  // low in reset and never depends on a same-cycle pop
  assign push = bus.desc_addr_valid_i & addr_rdy_q;
  // a new fetch may start only while no fetch is in flight
  assign pop  = (fifo_cnt != '0) & (32'(state != S_IDLE) < MaxOutstanding);
  assign head = fifo_q[rd_ptr];

  always_comb begin
    fifo_cnt_nxt = fifo_cnt + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr] <= bus.desc_addr_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      addr_rdy_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt   <= fifo_cnt_nxt;
      addr_rdy_q <= (fifo_cnt_nxt != CntW'(AddrFifoDepth));
    end
  end

  // beat placement and per-beat error: err flag, or last not exactly on beat 3
  assign rsp_hs   = rsp_rdy_q & bus.rd_rsp_valid_i;
  assign beat_err = bus.rd_rsp_err_i | (bus.rd_rsp_last_i != (beat_q == 2'd3));

  always_comb begin
    asm_nxt = asm_q;
    case (beat_q)
      2'd0:    begin
                 asm_nxt.flags  = bus.rd_rsp_data_i[31:0];
                 asm_nxt.length = bus.rd_rsp_data_i[63:32];
               end
      2'd1:    asm_nxt.next = bus.rd_rsp_data_i;
      2'd2:    asm_nxt.src  = bus.rd_rsp_data_i;
      default: asm_nxt.dst  = bus.rd_rsp_data_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      asm_q       <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      req_vld_q   <= 1'b0;
      rsp_rdy_q   <= 1'b0;
      err_pulse_q <= 1'b0;
`ifdef IDMA_DESC64_FETCH_OUT_BUF_EN
      out_q       <= '0;
      out_vld_q   <= 1'b0;
`else
      desc_vld_q  <= 1'b0;
`endif
    end else begin
      err_pulse_q <= 1'b0;
`ifdef IDMA_DESC64_FETCH_OUT_BUF_EN
      // consumed; a reload below in the same cycle overrides this
      if (out_vld_q & bus.desc_ready_i) out_vld_q <= 1'b0;
`endif
      case (state)
        S_IDLE: if (pop) begin
          if (head[2:0] != 3'd0) begin
            err_pulse_q <= 1'b1;
          end else begin
            asm_q.addr <= head;
            req_vld_q  <= 1'b1;
            state      <= S_REQ;
          end
        end
        S_REQ: if (bus.rd_req_ready_i) begin
          req_vld_q <= 1'b0;
          rsp_rdy_q <= 1'b1;
          beat_q    <= '0;
          err_q     <= 1'b0;
          state     <= S_RSP;
        end
        S_RSP: if (rsp_hs) begin
          asm_q  <= asm_nxt;
          beat_q <= beat_q + 2'd1;
          err_q  <= err_q | beat_err;
          if (bus.rd_rsp_last_i) begin
            rsp_rdy_q <= 1'b0;
            beat_q    <= '0;
            if (err_q | beat_err) begin
              err_pulse_q <= 1'b1;
              state       <= S_IDLE;
            end else begin
`ifdef IDMA_DESC64_FETCH_OUT_BUF_EN
              // load straight from the final beat to keep one-cycle latency
              if (out_free) begin
                out_q     <= asm_nxt;
                out_vld_q <= 1'b1;
                state     <= S_IDLE;
              end else begin
                state <= S_OUT;
              end
`else
              desc_vld_q <= 1'b1;
              state      <= S_OUT;
`endif
            end
          end
        end
        S_OUT: begin
`ifdef IDMA_DESC64_FETCH_OUT_BUF_EN
          if (out_free) begin
            out_q     <= asm_q;
            out_vld_q <= 1'b1;
            state     <= S_IDLE;
          end
`else
          if (bus.desc_ready_i) begin
            desc_vld_q <= 1'b0;
            state      <= S_IDLE;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.desc_addr_ready_o = addr_rdy_q;
  assign bus.rd_req_valid_o    = req_vld_q;
  assign bus.rd_req_addr_o     = asm_q.addr;
  assign bus.rd_req_len_o      = 8'd3;
  assign bus.rd_rsp_ready_o    = rsp_rdy_q;
  assign bus.fetch_err_o       = err_pulse_q;
  assign bus.busy_o            = (fifo_cnt != '0) | (state != S_IDLE);

`ifdef IDMA_DESC64_FETCH_OUT_BUF_EN
  assign bus.desc_valid_o  = out_vld_q;
  assign bus.desc_flags_o  = out_q.flags;
  assign bus.desc_length_o = out_q.length;
  assign bus.desc_next_o   = out_q.next;
  assign bus.desc_src_o    = out_q.src;
  assign bus.desc_dst_o    = out_q.dst;
  assign bus.desc_addr_o   = out_q.addr;
`else
  assign bus.desc_valid_o  = desc_vld_q;
  assign bus.desc_flags_o  = asm_q.flags;
  assign bus.desc_length_o = asm_q.length;
  assign bus.desc_next_o   = asm_q.next;
  assign bus.desc_src_o    = asm_q.src;
  assign bus.desc_dst_o    = asm_q.dst;
  assign bus.desc_addr_o   = asm_q.addr;
`endif
endmodule

// File: tb/tb_idma_desc64_desc_fetch.sv
// Testbench for idma_desc64_desc_fetch.
// Stimulus pushes addresses and records expected requests/descriptors/errors;
// a memory responder serves read bursts from a word map with injectable
// faults; a monitor pops expected descriptors at each output handshake.
`timescale 1ns/1ps
module tb_idma_desc64_desc_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  idma_desc64_desc_fetch_if bus();
  idma_desc64_desc_fetch #(.AddrFifoDepth(2)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  typedef struct packed {
    logic [31:0] flags;
    logic [31:0] length;
    logic [63:0] next;
    logic [63:0] src;
    logic [63:0] dst;
    logic [63:0] addr;
  } desc_t;

`ifdef IDMA_DESC64_FETCH_OUT_BUF_EN
  localparam bit BufEn = 1'b1;
`else
  localparam bit BufEn = 1'b0;
`endif

  int checks = 0, errors = 0, cyc = 0;
  int err_seen = 0, exp_err = 0, req_cnt = 0;
  int req_stall = 0, push_cyc = 0, last_beat_cyc = 0;
  int junk_req = 0, junk_done = 0;
  bit chk_lat = 1'b0;
  desc_t       exp_desc [$];
  logic [63:0] exp_req  [$];
  bit [63:0] mem        [bit [63:0]];
  int        err_beat   [bit [63:0]];
  int        last_beat  [bit [63:0]];
  int        drop_after [bit [63:0]];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endfunction

  function automatic void chk_desc(input string name, input desc_t act, input desc_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got addr=%h flags=%h len=%h next=%h src=%h dst=%h expected addr=%h flags=%h len=%h next=%h src=%h dst=%h",
               name, act.addr, act.flags, act.length, act.next, act.src, act.dst,
               exp.addr, exp.flags, exp.length, exp.next, exp.src, exp.dst);
    end
  endfunction

  function automatic desc_t sample_desc();
    desc_t d;
    d.flags  = bus.desc_flags_o;
    d.length = bus.desc_length_o;
    d.next   = bus.desc_next_o;
    d.src    = bus.desc_src_o;
    d.dst    = bus.desc_dst_o;
    d.addr   = bus.desc_addr_o;
    return d;
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    logic [63:0] a, e;
    int nb, t;
    bus.rd_req_ready_i = 1'b0;
    bus.rd_rsp_valid_i = 1'b0;
    bus.rd_rsp_data_i  = '0;
    bus.rd_rsp_last_i  = 1'b0;
    bus.rd_rsp_err_i   = 1'b0;
    forever begin
      @(negedge clk);
      if (junk_req != junk_done) begin
        // stray response traffic while no fetch is active
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          bus.rd_rsp_valid_i = 1'b1;
          bus.rd_rsp_data_i  = 64'hDEAD_BEEF_DEAD_BEEF;
          bus.rd_rsp_last_i  = 1'b1;
          bus.rd_rsp_err_i   = 1'b1;
          @(negedge clk);
          chk("rsp_ready_idle", bus.rd_rsp_ready_o, 0);
        end
        @(posedge clk); #1;
        bus.rd_rsp_valid_i = 1'b0;
        bus.rd_rsp_last_i  = 1'b0;
        bus.rd_rsp_err_i   = 1'b0;
        junk_done++;
      end else if (rst_n && bus.rd_req_valid_o) begin
        a = bus.rd_req_addr_o;
        if (chk_lat) chk("req_latency", 64'(cyc), 64'(push_cyc + 2));
        for (int k = 0; k < req_stall; k++) begin
          @(negedge clk);
          chk("req_hold_valid", bus.rd_req_valid_o, 1);
          chk("req_hold_addr", bus.rd_req_addr_o, a);
        end
        @(posedge clk); #1 bus.rd_req_ready_i = 1'b1;
        @(negedge clk);
        chk("req_valid_at_hs", bus.rd_req_valid_o, 1);
        req_cnt++;
        if (exp_req.size() == 0) fail("req_unexpected", $sformatf("got request %h, required none", a));
        else begin
          e = exp_req.pop_front();
          chk("req_addr", a, e);
        end
        chk("req_len", 64'(bus.rd_req_len_o), 3);
        @(posedge clk); #1 bus.rd_req_ready_i = 1'b0;
        nb = 4;
        if (last_beat.exists(a))  nb = last_beat[a] + 1;
        if (drop_after.exists(a)) nb = drop_after[a];
        for (int b = 0; b < nb; b++) begin
          bus.rd_rsp_valid_i = 1'b1;
          bus.rd_rsp_data_i  = mem.exists(a + 64'(8 * b)) ? mem[a + 64'(8 * b)] : 64'h0;
          bus.rd_rsp_last_i  = (b == nb - 1) && !drop_after.exists(a);
          bus.rd_rsp_err_i   = err_beat.exists(a) && (err_beat[a] == b);
          t = 0;
          @(negedge clk);
          while (!bus.rd_rsp_ready_o && t < 50) begin
            @(negedge clk);
            t++;
          end
          if (t >= 50) fail("rsp_beat_timeout", $sformatf("beat %0d not accepted after 50 cycles, required acceptance", b));
          last_beat_cyc = cyc;
          @(posedge clk); #1;
        end
        bus.rd_rsp_valid_i = 1'b0;
        bus.rd_rsp_last_i  = 1'b0;
        bus.rd_rsp_err_i   = 1'b0;
      end
    end
  end

  // ---------------- descriptor monitor / scoreboard ----------------
  initial begin
    desc_t cur, prev;
    bit pv, pr;
    pv = 1'b0;
    pr = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = sample_desc();
      if (!rst_n) begin
        pv = 1'b0;
        pr = 1'b0;
      end else begin
        if (pv && !pr) begin
          chk("desc_hold_valid", bus.desc_valid_o, 1);
          if (bus.desc_valid_o) chk_desc("desc_hold_data", cur, prev);
        end
        if (bus.desc_valid_o && !pv && chk_lat)
          chk("desc_latency", 64'(cyc), 64'(last_beat_cyc + 1));
        if (bus.desc_valid_o && bus.desc_ready_i) begin
          if (exp_desc.size() == 0)
            fail("desc_unexpected", $sformatf("got descriptor addr %h, required none", cur.addr));
          else
            chk_desc("desc", cur, exp_desc.pop_front());
        end
        pv = bus.desc_valid_o;
        pr = bus.desc_ready_i;
        prev = cur;
      end
    end
  end

  always @(negedge clk) if (rst_n && bus.fetch_err_o) err_seen++;

  // ---------------- stimulus ----------------
  task automatic push_addr(input logic [63:0] a);
    int t;
    @(posedge clk); #1;
    bus.desc_addr_i       = a;
    bus.desc_addr_valid_i = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.desc_addr_ready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail("push_timeout", $sformatf("address %h not accepted in 200 cycles", a));
    push_cyc = cyc;
    @(posedge clk); #1 bus.desc_addr_valid_i = 1'b0;
  endtask

  task automatic add_desc(input logic [63:0] a, input logic [31:0] fl, input logic [31:0] ln,
                          input logic [63:0] nx, input logic [63:0] sr, input logic [63:0] ds,
                          input bit ok);
    desc_t d;
    mem[a]      = {ln, fl};
    mem[a + 8]  = nx;
    mem[a + 16] = sr;
    mem[a + 24] = ds;
    exp_req.push_back(a);
    d = '{flags: fl, length: ln, next: nx, src: sr, dst: ds, addr: a};
    if (ok) exp_desc.push_back(d);
  endtask

  task automatic wait_quiet(input string name);
    int t;
    t = 0;
    repeat (3) @(negedge clk);
    while ((bus.busy_o || bus.desc_valid_o || exp_desc.size() != 0 || exp_req.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) fail({name, "_timeout"}, $sformatf("still busy after 500 cycles, %0d descriptors outstanding, required idle", exp_desc.size()));
    repeat (2) @(negedge clk);
    chk({name, "_err_pulses"}, 64'(err_seen), 64'(exp_err));
  endtask

  initial begin
    int r0, t;
    bus.desc_addr_i       = '0;
    bus.desc_addr_valid_i = 1'b0;
    bus.desc_ready_i      = 1'b1;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_addr_ready", bus.desc_addr_ready_o, 0);
    chk("rst_req_valid", bus.rd_req_valid_o, 0);
    chk("rst_rsp_ready", bus.rd_rsp_ready_o, 0);
    chk("rst_desc_valid", bus.desc_valid_o, 0);
    chk("rst_fetch_err", bus.fetch_err_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_desc_addr", bus.desc_addr_o, 0);
    chk("rst_desc_flags", 64'(bus.desc_flags_o), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("addr_ready_after_rst", bus.desc_addr_ready_o, 1);

    // single fetch with held request and latency checks
    mem[64'h1000] = 64'h0000_0040_0000_0001;
    mem[64'h1008] = 64'h2000;
    mem[64'h1010] = 64'hA000;
    mem[64'h1018] = 64'hB000;
    exp_req.push_back(64'h1000);
    exp_desc.push_back('{flags: 32'h1, length: 32'h40, next: 64'h2000,
                         src: 64'hA000, dst: 64'hB000, addr: 64'h1000});
    chk_lat = 1'b1;
    req_stall = 3;
    push_addr(64'h1000);
    wait_quiet("single");
    chk_lat = 1'b0;
    req_stall = 0;

    // misaligned address dropped, following aligned one fetched
    exp_err++;
    add_desc(64'h1008, 32'h11, 32'h80, 64'h3008, 64'hC000, 64'hD000, 1'b1);
    push_addr(64'h1004);
    push_addr(64'h1008);
    wait_quiet("misalign");

    // response error on beat 1
    add_desc(64'h3000, 32'h22, 32'h10, 64'h0, 64'h1, 64'h2, 1'b0);
    err_beat[64'h3000] = 1;
    exp_err++;
    push_addr(64'h3000);
    wait_quiet("rsp_err");

    // early last on beat 2, then a normal fetch
    add_desc(64'h4000, 32'h33, 32'h20, 64'h4, 64'h5, 64'h6, 1'b0);
    last_beat[64'h4000] = 2;
    exp_err++;
    add_desc(64'h5000, 32'h44, 32'h100, 64'h5020, 64'hE000, 64'hF000, 1'b1);
    push_addr(64'h4000);
    push_addr(64'h5000);
    wait_quiet("early_last");

    // stray response traffic while idle is ignored
    junk_req++;
    t = 0;
    while (junk_done != junk_req && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail("junk_timeout", "stray response sequence did not complete");
    add_desc(64'h5800, 32'h55, 32'h8, 64'h58, 64'h59, 64'h5A, 1'b1);
    push_addr(64'h5800);
    wait_quiet("junk");

    // output back-pressure with three queued addresses
    bus.desc_ready_i = 1'b0;
    add_desc(64'h6000, 32'h66, 32'h60, 64'h7000, 64'h6100, 64'h6200, 1'b1);
    add_desc(64'h7000, 32'h77, 32'h70, 64'h8000, 64'h7100, 64'h7200, 1'b1);
    add_desc(64'h8000, 32'h88, 32'h80, 64'h0,    64'h8100, 64'h8200, 1'b1);
    push_addr(64'h6000);
    push_addr(64'h7000);
    push_addr(64'h8000);
    t = 0;
    while (!bus.desc_valid_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail("stall_desc_timeout", "descriptor never presented");
    r0 = req_cnt;
    repeat (20) @(negedge clk);
    chk("stall_new_reqs", 64'(req_cnt - r0), BufEn ? 64'd1 : 64'd0);
    chk("stall_addr_ready", bus.desc_addr_ready_o, BufEn ? 1 : 0);
    chk("stall_desc_valid", bus.desc_valid_o, 1);
    chk("stall_desc_addr", bus.desc_addr_o, 64'h6000);
    @(posedge clk); #1 bus.desc_ready_i = 1'b1;
    wait_quiet("stall");

    // reset in the middle of a response burst
    add_desc(64'h9000, 32'h99, 32'h90, 64'h1, 64'h2, 64'h3, 1'b0);
    drop_after[64'h9000] = 2;
    r0 = req_cnt;
    push_addr(64'h9000);
    t = 0;
    while (req_cnt == r0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail("midrst_req_timeout", "request never issued");
    repeat (8) @(negedge clk);
    chk("midrst_in_rsp", bus.rd_rsp_ready_o, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_ready", bus.rd_rsp_ready_o, 0);
    chk("midrst_busy", bus.busy_o, 0);
    chk("midrst_desc_valid", bus.desc_valid_o, 0);
    chk("midrst_fetch_err", bus.fetch_err_o, 0);
    chk("midrst_addr_ready", bus.desc_addr_ready_o, 0);
    chk("midrst_desc_addr", bus.desc_addr_o, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    add_desc(64'hA000, 32'hAA, 32'hA0, 64'hA1, 64'hA2, 64'hA3, 1'b1);
    push_addr(64'hA000);
    wait_quiet("after_reset");

    chk("exp_desc_left", 64'(exp_desc.size()), 0);
    chk("exp_req_left", 64'(exp_req.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded 500us, required completion");
    $fatal(1, "watchdog");
  end
endmodule
